// File: rtl/alu_arbiter_if.sv
// Calculator types and the bundled requester/ALU handshake bus for alu_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// surrounding logic, meaning the requesters plus the ALU.

package calc_pkg;
  typedef logic [15:0] num_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
endpackage

interface alu_arbiter_if #(
  parameter int NumRequesters = 2
);
  import calc_pkg::*;

  localparam int IdxW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

  // requester operand ports
  num_t                     req_left_i  [NumRequesters];
  num_t                     req_right_i [NumRequesters];
  op_t                      req_op_i    [NumRequesters];
  logic [NumRequesters-1:0] req_in_valid_i;
  logic [NumRequesters-1:0] req_in_ready_o;

  // requester result ports (shared data bus, per-requester valid/ready)
  num_t                     req_result_o;
  logic [NumRequesters-1:0] req_out_valid_o;
  logic [NumRequesters-1:0] req_out_ready_i;

  // ALU side
  num_t                     alu_left_o;
  num_t                     alu_right_o;
  op_t                      alu_op_o;
  logic                     alu_in_valid_o;
  logic                     alu_in_ready_i;
  num_t                     alu_result_i;
  logic                     alu_out_valid_i;
  logic                     alu_out_ready_o;

  // status
  logic                     busy_o;
  logic [IdxW-1:0]          owner_o;

  modport slave (
    input  req_left_i, req_right_i, req_op_i, req_in_valid_i,
    output req_in_ready_o,
    output req_result_o, req_out_valid_o,
    input  req_out_ready_i,
    output alu_left_o, alu_right_o, alu_op_o, alu_in_valid_o,
    input  alu_in_ready_i,
    input  alu_result_i, alu_out_valid_i,
    output alu_out_ready_o,
    output busy_o, owner_o
  );

  modport master (
    output req_left_i, req_right_i, req_op_i, req_in_valid_i,
    input  req_in_ready_o,
    input  req_result_o, req_out_valid_o,
    output req_out_ready_i,
    input  alu_left_o, alu_right_o, alu_op_o, alu_in_valid_o,
    output alu_in_ready_i,
    output alu_result_i, alu_out_valid_i,
    input  alu_out_ready_o,
    input  busy_o, owner_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one calculator ALU among NumRequesters ports.
// Only one operation is in flight at a time. The operands and the result are
// buffered in registers. The result is returned only to the requester that
// issued the operation.
//
// state          | meaning
// S_IDLE         | waiting for a valid request, granting from ptr_q upward
// S_ISSUE        | captured operands offered to the ALU
// S_WAIT_RESULT  | waiting for the ALU result
// S_RETURN       | buffered result offered to the owning requester

module alu_arbiter #(
  parameter int NumRequesters = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_arbiter_if.slave  bus
);
  import calc_pkg::*;

  localparam int IdxW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESULT,
    S_RETURN
  } state_t;

  state_t                   state_q;
  logic [IdxW-1:0]          ptr_q;
  logic [IdxW-1:0]          owner_q;
  num_t                     left_q;
  num_t                     right_q;
  op_t                      op_q;
  num_t                     result_q;
  logic                     alu_in_valid_q;
  logic                     alu_out_ready_q;
  logic [NumRequesters-1:0] out_valid_q;
  logic                     busy_q;

  logic                     grant_found;
  logic [IdxW-1:0]          grant_idx;
  logic [NumRequesters-1:0] grant_oh;

  function automatic logic [NumRequesters-1:0] to_onehot(input logic [IdxW-1:0] idx);
    logic [NumRequesters-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // First valid requester at or after ptr_q, wrapping around the port list.
  always_comb begin : grant_search
    logic [IdxW-1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NumRequesters; k++) begin
      cand = IdxW'((int'(ptr_q) + k) % NumRequesters);
      if (!grant_found && bus.req_in_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_oh = grant_found ? to_onehot(grant_idx) : '0;
  end

  // The grant is the only combinational path from an input to an output.
  assign bus.req_in_ready_o  = (state_q == S_IDLE) ? grant_oh : '0;

  assign bus.alu_left_o      = left_q;
  assign bus.alu_right_o     = right_q;
  assign bus.alu_op_o        = op_q;
  assign bus.alu_in_valid_o  = alu_in_valid_q;
  assign bus.alu_out_ready_o = alu_out_ready_q;
  assign bus.req_result_o    = result_q;
  assign bus.req_out_valid_o = out_valid_q;
  assign bus.busy_o          = busy_q;
  assign bus.owner_o         = owner_q;

  // Sequencing FSM. Every output that faces the ALU or a requester is updated
  // together with the state transition, so all of these outputs are registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      ptr_q           <= '0;
      owner_q         <= '0;
      left_q          <= '0;
      right_q         <= '0;
      op_q            <= OP_ADD;
      result_q        <= '0;
      alu_in_valid_q  <= 1'b0;
      alu_out_ready_q <= 1'b0;
      out_valid_q     <= '0;
      busy_q          <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            left_q         <= bus.req_left_i[grant_idx];
            right_q        <= bus.req_right_i[grant_idx];
            op_q           <= bus.req_op_i[grant_idx];
            owner_q        <= grant_idx;
            ptr_q          <= (grant_idx == IdxW'(NumRequesters - 1)) ? '0
                                                                      : grant_idx + IdxW'(1);
            alu_in_valid_q <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.alu_in_ready_i) begin
            alu_in_valid_q  <= 1'b0;
            alu_out_ready_q <= 1'b1;
            state_q         <= S_WAIT_RESULT;
          end
        end
        S_WAIT_RESULT: begin
          if (bus.alu_out_valid_i) begin
            result_q        <= bus.alu_result_i;
            alu_out_ready_q <= 1'b0;
            out_valid_q     <= to_onehot(owner_q);
            state_q         <= S_RETURN;
          end
        end
        S_RETURN: begin
          // Ready bits from requesters other than the owner are ignored.
          if (bus.req_out_ready_i[owner_q]) begin
            out_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter, using two requesters and a behavioural
// ALU that can stall.
module tb_alu_arbiter;
  import calc_pkg::*;

  localparam int N = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  alu_arbiter_if #(.NumRequesters(N)) bus ();
  alu_arbiter #(.NumRequesters(N)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0] mask;
    logic [1:0] busy_mask;
    num_t       l0, r0, l1, r1;
    op_t        o0, o1;
    int         exp_owner;
    num_t       exp_res;
    int         st_in, st_out, st_req;
  } vec_t;

  vec_t vecs[9];
  vec_t post_rst;

  function automatic vec_t mk(logic [1:0] mask, logic [1:0] busy_mask,
                              num_t l0, num_t r0, op_t o0,
                              num_t l1, num_t r1, op_t o1,
                              int exp_owner, num_t exp_res,
                              int st_in, int st_out, int st_req);
    vec_t v;
    v.mask = mask; v.busy_mask = busy_mask;
    v.l0 = l0; v.r0 = r0; v.o0 = o0;
    v.l1 = l1; v.r1 = r1; v.o1 = o1;
    v.exp_owner = exp_owner; v.exp_res = exp_res;
    v.st_in = st_in; v.st_out = st_out; v.st_req = st_req;
    return v;
  endfunction

  function automatic num_t alu_model(num_t a, num_t b, op_t op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return num_t'(a * b);
      default: return (b == '0) ? '0 : a / b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One complete transaction, with the given stall counts on each handshake.
  task automatic do_op(input vec_t v);
    logic [1:0] own_oh;
    num_t el, er;
    op_t  eo;
    int   c;
    own_oh = 2'(1 << v.exp_owner);
    el = (v.exp_owner == 0) ? v.l0 : v.l1;
    er = (v.exp_owner == 0) ? v.r0 : v.r1;
    eo = (v.exp_owner == 0) ? v.o0 : v.o1;
    bus.req_left_i[0] = v.l0; bus.req_right_i[0] = v.r0; bus.req_op_i[0] = v.o0;
    bus.req_left_i[1] = v.l1; bus.req_right_i[1] = v.r1; bus.req_op_i[1] = v.o1;
    bus.req_in_valid_i = v.mask;
    #1;
    chk("grant_ready", 32'(bus.req_in_ready_o), 32'(own_oh));
    @(posedge clk_i); #1;
    c = 1;
    bus.req_in_valid_i = v.busy_mask;
    for (int i = 0; i < N; i++) begin
      bus.req_left_i[i] = 16'hFFFF; bus.req_right_i[i] = 16'hFFFF; bus.req_op_i[i] = OP_DIV;
    end
    for (int s = 0; s <= v.st_in; s++) begin
      bus.alu_in_ready_i = (s == v.st_in);
      #1;
      chk("issue_valid", 32'(bus.alu_in_valid_o), 32'd1);
      chk("issue_left",  32'(bus.alu_left_o), 32'(el));
      chk("issue_right", 32'(bus.alu_right_o), 32'(er));
      chk("issue_op",    32'(bus.alu_op_o), 32'(eo));
      chk("issue_owner", 32'(bus.owner_o), 32'(v.exp_owner));
      chk("issue_busy",  32'(bus.busy_o), 32'd1);
      chk("issue_no_ready", 32'(bus.req_in_ready_o), 32'd0);
      @(posedge clk_i); #1;
      c++;
    end
    bus.alu_in_ready_i = 1'b0;
    for (int s = 0; s <= v.st_out; s++) begin
      bus.alu_out_valid_i = (s == v.st_out);
      bus.alu_result_i = (s == v.st_out) ? alu_model(bus.alu_left_o, bus.alu_right_o, bus.alu_op_o)
                                         : 16'hDEAD;
      #1;
      chk("wait_out_ready", 32'(bus.alu_out_ready_o), 32'd1);
      chk("wait_in_valid",  32'(bus.alu_in_valid_o), 32'd0);
      chk("wait_no_ready",  32'(bus.req_in_ready_o), 32'd0);
      chk("wait_no_result", 32'(bus.req_out_valid_o), 32'd0);
      @(posedge clk_i); #1;
      c++;
    end
    bus.alu_out_valid_i = 1'b0;
    bus.alu_result_i = 16'hBEEF;
    for (int s = 0; s <= v.st_req; s++) begin
      bus.req_out_ready_i = (s == v.st_req) ? own_oh : ~own_oh;
      #1;
      chk("ret_valid",     32'(bus.req_out_valid_o), 32'(own_oh));
      chk("ret_result",    32'(bus.req_result_o), 32'(v.exp_res));
      chk("ret_alu_ready", 32'(bus.alu_out_ready_o), 32'd0);
      chk("ret_no_ready",  32'(bus.req_in_ready_o), 32'd0);
      @(posedge clk_i); #1;
      c++;
    end
    bus.req_out_ready_i = '0;
    bus.req_in_valid_i = '0;
    #1;
    chk("done_busy",    32'(bus.busy_o), 32'd0);
    chk("done_valid",   32'(bus.req_out_valid_o), 32'd0);
    chk("done_latency", 32'(c), 32'(4 + v.st_in + v.st_out + v.st_req));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(2'b01, 2'b00, 12, 3, OP_ADD,   0, 0, OP_ADD, 0, 15,    0, 0, 0);
    vecs[1] = mk(2'b11, 2'b11, 20, 5, OP_SUB,   7, 6, OP_MUL, 1, 42,    0, 0, 0);
    vecs[2] = mk(2'b11, 2'b11, 100, 7, OP_DIV,  1, 1, OP_ADD, 0, 14,    0, 0, 0);
    vecs[3] = mk(2'b11, 2'b11, 9, 9, OP_ADD,   50, 8, OP_SUB, 1, 42,    0, 0, 0);
    vecs[4] = mk(2'b10, 2'b11, 1, 2, OP_ADD,    3, 4, OP_MUL, 1, 12,    3, 5, 2);
    vecs[5] = mk(2'b11, 2'b00, 16'hFFFF, 1, OP_ADD, 2, 2, OP_ADD, 0, 0, 0, 0, 1);
    vecs[6] = mk(2'b01, 2'b00, 5, 10, OP_SUB,   0, 0, OP_ADD, 0, 16'hFFFB, 1, 0, 0);
    vecs[7] = mk(2'b01, 2'b10, 200, 3, OP_DIV,  9, 9, OP_ADD, 0, 66,    0, 2, 0);
    vecs[8] = mk(2'b11, 2'b00, 4, 4, OP_ADD,    6, 7, OP_MUL, 1, 42,    0, 0, 0);
    post_rst = mk(2'b11, 2'b00, 30, 12, OP_SUB, 5, 5, OP_ADD, 0, 18,    0, 0, 0);

    rst_i = 1'b1;
    bus.req_in_valid_i = '0;
    bus.req_out_ready_i = '0;
    bus.alu_in_ready_i = 1'b0;
    bus.alu_out_valid_i = 1'b0;
    bus.alu_result_i = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_left_i[i] = '0; bus.req_right_i[i] = '0; bus.req_op_i[i] = OP_ADD;
    end
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("rst_busy",      32'(bus.busy_o), 32'd0);
    chk("rst_in_valid",  32'(bus.alu_in_valid_o), 32'd0);
    chk("rst_out_ready", 32'(bus.alu_out_ready_o), 32'd0);
    chk("rst_out_valid", 32'(bus.req_out_valid_o), 32'd0);
    chk("rst_owner",     32'(bus.owner_o), 32'd0);
    chk("rst_result",    32'(bus.req_result_o), 32'd0);
    chk("rst_left",      32'(bus.alu_left_o), 32'd0);
    chk("rst_no_grant",  32'(bus.req_in_ready_o), 32'd0);

    for (int k = 0; k < 9; k++) do_op(vecs[k]);

    // Reset while waiting for the ALU. ptr_q is 1 just before the reset, so a
    // grant to requester 0 afterwards shows that the pointer was reset too.
    bus.req_left_i[0] = 8; bus.req_right_i[0] = 2; bus.req_op_i[0] = OP_SUB;
    bus.req_in_valid_i = 2'b01;
    @(posedge clk_i); #1;
    bus.req_in_valid_i = 2'b00;
    bus.alu_in_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.alu_in_ready_i = 1'b0;
    chk("rw_out_ready", 32'(bus.alu_out_ready_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    chk("rw_busy",      32'(bus.busy_o), 32'd0);
    chk("rw_out_ready0", 32'(bus.alu_out_ready_o), 32'd0);
    chk("rw_owner",     32'(bus.owner_o), 32'd0);
    bus.alu_out_valid_i = 1'b1;
    bus.alu_result_i = 16'd6;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk_i); #1;
      chk("rw_no_result", 32'(bus.req_out_valid_o), 32'd0);
      chk("rw_idle",      32'(bus.busy_o), 32'd0);
    end
    bus.alu_out_valid_i = 1'b0;
    do_op(post_rst);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
